cam_capture_ctrl: RTL and testbench
===================================

// Module: cam_capture_ctrl
// PURPOSE
//  Parametrised OV7670 capture engine, successor to the fixed RGB565 interface. Synchronises
//  camera signals into sys_clk, assembles 2-byte pixels in RGB565 or YUV422-to-gray mode, with
//  optional power-of-2 decimation and frame-integrity checks. Pixels leave via a valid/ready
//  FIFO toward the frame-buffer writer that feeds gesture detection.
// PARAMETERS
//  H_ACTIVE    640  active pixels per line (camera side)
//  V_ACTIVE    480  active lines per frame (camera side)
//  DECIM_LOG2  0    keep 1 of 2^DECIM_LOG2 pixels in x and y (0..3)
//  ADDR_WIDTH  19   pix_addr width; must hold (H_ACTIVE*V_ACTIVE)>>(2*DECIM_LOG2)
//  FIFO_DEPTH  8    output FIFO entries, power of 2, >=2
// PORTS
//  sys_clk      in   1   system clock, 100 MHz
//  rst_n        in   1   asynchronous active-low reset
//  cam_pclk     in   1   camera pixel clock (sampled as data, >=4x slower than sys_clk)
//  cam_vsync    in   1   vertical sync, high = blanking
//  cam_href     in   1   line-valid
//  cam_data     in   8   camera byte
//  capture_en   in   1   arm capture; sampled only at frame start
//  cfg_mode     in   1   0 = RGB565 {b0,b1}; 1 = YUV422 gray {Y[7:3],Y[7:2],Y[7:3]}, Y = b0
//  pix_data     out  16  pixel word
//  pix_addr     out  ADDR_WIDTH  linear address of pix_data in the decimated frame
//  pix_valid    out  1   FIFO not empty
//  pix_ready    in   1   consumer accepts when pix_valid && pix_ready
//  frame_done   out  1   1-cycle pulse at end of a captured frame
//  frame_err    out  1   1-cycle pulse coincident with frame_done if the frame was bad
//  overflow     out  1   sticky: pixel dropped on full FIFO; cleared at next frame start
//  frame_count  out  16  captured frames, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state IDLE, counters 0; async assert, sync deassert.
//  - 2-FF sync on pclk, vsync, href; data through 2 FFs aligned with pclk. Capture event =
//    rising edge of synced pclk while synced href = 1.
//  - FSM: IDLE -> ARMED on vsync falling edge with capture_en=1 (cfg_mode latched, counters and
//    overflow cleared). ARMED/ACTIVE -> IDLE on vsync rising edge (frame_done pulse).
//    Without capture_en the frame is ignored: no frame_done, no pixels.
//  - Byte toggle returns to 0 while href = 0; an odd trailing byte is discarded.
//  - x_cnt counts pixels per line and clears when href falls, which increments y_cnt.
//    Pixel is kept iff x_cnt[D-1:0]==0 and y_cnt[D-1:0]==0 (D = DECIM_LOG2, all kept if D=0).
//  - pix_addr: running counter of kept pixels, starts at 0 per frame; written with data.
//  - Latency: 2nd byte capture event -> FIFO write next cycle -> pix_valid 1 cycle later
//    if FIFO was empty (3 sys_clk from synced pclk edge).
//  - FIFO full at write: pixel dropped, address still increments (holes are detectable),
//    overflow sets. Simultaneous read and write when full: the read frees the slot and the
//    write succeeds.
//  - frame_err = overflow OR y_cnt != V_ACTIVE OR any line with x_cnt != H_ACTIVE.
//  - vsync rising mid-pixel: half-pixel discarded, frame closes normally (err per above).
//  - frame_count increments on frame_done. FIFO contents persist across frames and are
//    drained by the consumer; the FIFO is not flushed at frame start.
//  - capture_en falling mid-frame has no effect until the next frame start.
// STRUCTURE
//  - Package cam_pkg: MODE_RGB565/MODE_GRAY constants, FSM state encoding
//    (IDLE, ARMED, ACTIVE), gray expansion function.
//  - Sub-module cam_pix_fifo: sync FIFO, width 16+ADDR_WIDTH, depth FIFO_DEPTH, with full/empty.
//  - Top: synchronisers, edge detection, FSM, counters, pixel assembly.
// TESTING
//  1. 4x2 frame, RGB565, D=0, pix_ready=1, bytes 0xF8,0x00,... -> 8 pixels 0xF800 at addr 0..7,
//     frame_done=1, frame_err=0, frame_count=1.
//  2. cfg_mode=1, Y byte 0x80 -> pix_data=0x8410; U/V byte ignored.
//  3. D=1, 8x4 frame -> 8 pixels with addr 0..7 from even x/even y only; frame_err=0.
//  4. pix_ready=0, FIFO_DEPTH=8, 12 pixels -> 8 held, overflow=1, frame_err pulses with
//     frame_done; then drain -> addresses 0..7.
//  5. Line short by 1 pixel, plus odd byte before href fall -> frame_err=1, odd byte dropped.
//  6. capture_en=0 at vsync fall -> no pix_valid, no frame_done; rst_n low mid-line ->
//     immediate idle, all outputs 0.

Source files
------------

// File: rtl/cam_capture_ctrl_pkg.sv
// cam_pkg: shared pixel modes, capture FSM encoding and pixel assembly helpers
// for the OV7670 capture engine.
package cam_pkg;
    localparam logic MODE_RGB565 = 1'b0;
    localparam logic MODE_GRAY   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } cap_state_e;

    function automatic logic [15:0] gray565(input logic [7:0] y);
        return {y[7:3], y[7:2], y[7:3]};
    endfunction

    function automatic logic [15:0] assemble(input logic mode, input logic [7:0] b0, input logic [7:0] b1);
        return (mode == MODE_GRAY) ? gray565(b0) : {b0, b1};
    endfunction
endpackage

// File: rtl/cam_capture_ctrl_fifo.sv
// cam_pix_fifo: synchronous FIFO of {pixel, address} words; a read on a full FIFO
// frees the slot so a write in the same cycle still lands.
module cam_pix_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_wr, do_rd;

    assign empty   = wr_ptr_q == rd_ptr_q;
    assign full    = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk)
        if (do_wr) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: OV7670 capture engine -- brings camera signals into sys_clk, assembles
// RGB565 or gray pixels with optional decimation and queues them with addresses.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DECIM_LOG2 = 0,
    parameter int ADDR_WIDTH = 19,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  cam_pclk,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [7:0]            cam_data,
    input  logic                  capture_en,
    input  logic                  cfg_mode,
    output logic [15:0]           pix_data,
    output logic [ADDR_WIDTH-1:0] pix_addr,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  overflow,
    output logic [15:0]           frame_count
);
    localparam int            CW    = 16;
    localparam logic [CW-1:0] DMASK = CW'((1 << DECIM_LOG2) - 1);
    localparam int            FW    = 16 + ADDR_WIDTH;

    logic                  rst_meta_q, rst_sync_q;
    logic [2:0]            pclk_q, vsync_q, href_q;
    logic [7:0]            data_s1_q, data_s2_q;
    cap_state_e            state_q, state_d;
    logic                  mode_q, tog_q, line_err_q, ovf_q;
    logic [7:0]            b0_q;
    logic [CW-1:0]         x_q, y_q, y_eff;
    logic [ADDR_WIDTH-1:0] addr_q, wr_addr_q;
    logic                  wr_q;
    logic [15:0]           wr_data_q, count_q;
    logic                  done_q, err_q;
    logic                  pclk_rise, vs_rise, vs_fall, href_s, href_fall;
    logic                  in_frame, frame_start, frame_end, cap, pix_done, keep;
    logic                  fifo_full, fifo_empty, drop, lerr_eff, bad;
    logic [FW-1:0]         fifo_rd_data;

    // Reset asserts immediately but releases only after two clean sys_clk edges.
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) {rst_sync_q, rst_meta_q} <= 2'b00;
        else        {rst_sync_q, rst_meta_q} <= {rst_meta_q, 1'b1};

    always_ff @(posedge sys_clk or negedge rst_sync_q)
        if (!rst_sync_q) begin
            pclk_q    <= '0;
            vsync_q   <= '0;
            href_q    <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            pclk_q    <= {pclk_q[1:0], cam_pclk};
            vsync_q   <= {vsync_q[1:0], cam_vsync};
            href_q    <= {href_q[1:0], cam_href};
            data_s1_q <= cam_data;
            data_s2_q <= data_s1_q;
        end

    assign href_s      = href_q[1];
    assign pclk_rise   = pclk_q[1] & ~pclk_q[2];
    assign vs_rise     = vsync_q[1] & ~vsync_q[2];
    assign vs_fall     = ~vsync_q[1] & vsync_q[2];
    assign href_fall   = ~href_q[1] & href_q[2];
    assign in_frame    = state_q != IDLE;
    assign frame_start = (state_q == IDLE) & vs_fall & capture_en;
    assign frame_end   = in_frame & vs_rise;
    assign cap         = in_frame & pclk_rise & href_s & ~vs_rise;
    assign pix_done    = cap & tog_q;
    assign keep        = ((x_q & DMASK) == '0) && ((y_q & DMASK) == '0);
    assign drop        = wr_q & fifo_full & ~pix_ready;

    // A line ending in the same cycle as vsync still counts toward the frame check.
    assign y_eff    = y_q + CW'(href_fall);
    assign lerr_eff = line_err_q | (href_fall & (x_q != CW'(H_ACTIVE)));
    assign bad      = ovf_q | drop | (y_eff != CW'(V_ACTIVE)) | lerr_eff;

    always_ff @(posedge sys_clk or negedge rst_sync_q)
        if (!rst_sync_q) state_q <= IDLE;
        else             state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start) state_d = ARMED;
            ARMED:   state_d = vs_rise ? IDLE : (cap ? ACTIVE : ARMED);
            default: if (vs_rise) state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_sync_q)
        if (!rst_sync_q) begin
            mode_q     <= MODE_RGB565;
            tog_q      <= 1'b0;
            b0_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            line_err_q <= 1'b0;
            addr_q     <= '0;
        end else if (frame_start) begin
            mode_q     <= cfg_mode;
            tog_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            line_err_q <= 1'b0;
            addr_q     <= '0;
        end else if (!in_frame) begin
            tog_q <= 1'b0;
        end else begin
            if (!href_s || vs_rise) tog_q <= 1'b0;
            else if (cap)           tog_q <= ~tog_q;
            if (cap && !tog_q) b0_q <= data_s2_q;
            if (pix_done) begin
                x_q <= x_q + 1'b1;
                if (keep) addr_q <= addr_q + 1'b1;
            end
            if (href_fall) begin
                x_q <= '0;
                y_q <= y_q + 1'b1;
                if (x_q != CW'(H_ACTIVE)) line_err_q <= 1'b1;
            end
        end

    always_ff @(posedge sys_clk or negedge rst_sync_q)
        if (!rst_sync_q) begin
            wr_q      <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            wr_q      <= pix_done & keep;
            wr_data_q <= assemble(mode_q, b0_q, data_s2_q);
            wr_addr_q <= addr_q;
            if (frame_start) ovf_q <= 1'b0;
            else if (drop)   ovf_q <= 1'b1;
            done_q    <= frame_end;
            err_q     <= frame_end & bad;
            count_q   <= count_q + 16'(frame_end);
        end

    cam_pix_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (sys_clk),
        .rst_n  (rst_sync_q),
        .wr_en  (wr_q),
        .wr_data({wr_data_q, wr_addr_q}),
        .rd_en  (pix_ready),
        .rd_data(fifo_rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign {pix_data, pix_addr} = fifo_rd_data;
    assign pix_valid   = ~fifo_empty;
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign overflow    = ovf_q;
    assign frame_count = count_q;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: directed camera frames into a full-resolution and a 2x-decimated engine,
// checked every cycle against a frame-level model of expected pixels and frame results.
module tb_cam_capture_ctrl;
    typedef struct packed {
        logic [15:0] d;
        logic [18:0] a;
    } pix_t;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        pclk = 1'b0, vsync = 1'b1, href = 1'b0, mode = 1'b0, ready = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        en [2];
    logic [15:0] pd [2];
    logic [18:0] pa [2];
    logic        pv [2], fd [2], fe [2], ov [2];
    logic [15:0] fc [2];

    int          tests = 0, fails = 0;
    pix_t        exp_pix [2][$];
    logic        exp_err [2][$];
    int          cnt_exp [2];
    int          npop [2];
    logic [15:0] last_d [2];
    logic [18:0] last_a [2];
    logic        last_e [2];

    always #5 clk = ~clk;

    cam_capture_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM_LOG2(0), .ADDR_WIDTH(19), .FIFO_DEPTH(8)) dut0 (
        .sys_clk(clk), .rst_n(rst_n), .cam_pclk(pclk), .cam_vsync(vsync), .cam_href(href),
        .cam_data(data), .capture_en(en[0]), .cfg_mode(mode), .pix_data(pd[0]), .pix_addr(pa[0]),
        .pix_valid(pv[0]), .pix_ready(ready), .frame_done(fd[0]), .frame_err(fe[0]),
        .overflow(ov[0]), .frame_count(fc[0]));

    cam_capture_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM_LOG2(1), .ADDR_WIDTH(19), .FIFO_DEPTH(8)) dut1 (
        .sys_clk(clk), .rst_n(rst_n), .cam_pclk(pclk), .cam_vsync(vsync), .cam_href(href),
        .cam_data(data), .capture_en(en[1]), .cfg_mode(mode), .pix_data(pd[1]), .pix_addr(pa[1]),
        .pix_valid(pv[1]), .pix_ready(ready), .frame_done(fd[1]), .frame_err(fe[1]),
        .overflow(ov[1]), .frame_count(fc[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int h_of(input int k); return k ? 8 : 4; endfunction
    function automatic int v_of(input int k); return k ? 4 : 2; endfunction
    function automatic int step_of(input int k); return k ? 2 : 1; endfunction

    function automatic logic [7:0] byte0(input bit vary, input int x, input int y, input logic [7:0] c);
        return vary ? 8'(x * 29 + y * 7 + 3) : c;
    endfunction
    function automatic logic [7:0] byte1(input bit vary, input int x, input int y, input logic [7:0] c);
        return vary ? 8'(x * 13 + y * 5 + 90) : c;
    endfunction
    function automatic logic [15:0] pix_word(input bit md, input logic [7:0] b0, input logic [7:0] b1);
        return md ? {b0[7:3], b0[7:2], b0[7:3]} : {b0, b1};
    endfunction

    // Expected output of engine k for one frame: kept pixels in order, holes when stalled.
    task automatic model_frame(input int k, input bit md, input bit stall, input int lines, input int ppl,
                               input int short_ln, input bit vary, input logic [7:0] c0, input logic [7:0] c1);
        int a = 0, held = 0, n;
        bit bad;
        bad = (lines != v_of(k));
        for (int y = 0; y < lines; y++) begin
            n = (y == short_ln) ? ppl - 1 : ppl;
            if (n != h_of(k)) bad = 1;
            for (int x = 0; x < n; x++) begin
                if (x % step_of(k) == 0 && y % step_of(k) == 0) begin
                    if (!stall || held < 8) begin
                        exp_pix[k].push_back('{pix_word(md, byte0(vary, x, y, c0), byte1(vary, x, y, c1)), 19'(a)});
                        held++;
                    end else bad = 1;
                    a++;
                end
            end
        end
        exp_err[k].push_back(bad);
    endtask

    task automatic cyc(input int n); #(80 * n); endtask
    task automatic put(input logic [7:0] b); data = b; #40 pclk = 1'b1; #40 pclk = 1'b0; endtask

    task automatic send_frame(input bit e0, input bit e1, input bit md, input bit stall, input int lines,
                              input int ppl, input int short_ln, input bit odd, input bit vary,
                              input logic [7:0] c0, input logic [7:0] c1);
        int n;
        if (e0) model_frame(0, md, stall, lines, ppl, short_ln, vary, c0, c1);
        if (e1) model_frame(1, md, stall, lines, ppl, short_ln, vary, c0, c1);
        en[0] = e0; en[1] = e1; mode = md; ready = !stall;
        cyc(2);
        vsync = 1'b0;
        cyc(2);
        for (int y = 0; y < lines; y++) begin
            n = (y == short_ln) ? ppl - 1 : ppl;
            href = 1'b1;
            for (int x = 0; x < n; x++) begin
                put(byte0(vary, x, y, c0));
                put(byte1(vary, x, y, c1));
            end
            if (y == short_ln && odd) put(8'h77);
            href = 1'b0;
            cyc(2);
        end
        vsync = 1'b1;
        cyc(2);
        en[0] = 1'b0; en[1] = 1'b0;
    endtask

    task automatic wait_empty(input int k, input bit pix);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_err[k].size() != 0 || (pix && exp_pix[k].size() != 0)) && t < 400);
        chk($sformatf("dut%0d frame result seen", k), 64'(exp_err[k].size()), 0);
        if (pix) chk($sformatf("dut%0d pixels drained", k), 64'(exp_pix[k].size()), 0);
        #6;
    endtask

    always @(negedge clk) begin : mon
        pix_t e;
        if (rst_n) for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d frame_err only with frame_done", i), 64'(fe[i] & ~fd[i]), 0);
            if (pv[i] && ready) begin
                chk($sformatf("dut%0d pixel expected", i), 64'(exp_pix[i].size() != 0), 1);
                if (exp_pix[i].size() != 0) begin
                    e = exp_pix[i].pop_front();
                    chk($sformatf("dut%0d pix_data", i), pd[i], e.d);
                    chk($sformatf("dut%0d pix_addr", i), pa[i], e.a);
                    last_d[i] = pd[i];
                    last_a[i] = pa[i];
                    npop[i]++;
                end
            end
            if (fd[i]) begin
                chk($sformatf("dut%0d frame_done expected", i), 64'(exp_err[i].size() != 0), 1);
                if (exp_err[i].size() != 0) begin
                    chk($sformatf("dut%0d frame_err", i), fe[i], exp_err[i].pop_front());
                    cnt_exp[i]++;
                    chk($sformatf("dut%0d frame_count", i), fc[i], 64'(cnt_exp[i] & 16'hFFFF));
                    last_e[i] = fe[i];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        en[0] = 1'b0; en[1] = 1'b0;
        cnt_exp[0] = 0; cnt_exp[1] = 0; npop[0] = 0; npop[1] = 0;
        #1 rst_n = 1'b0;
        #5;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset pix_valid%0d", i), pv[i], 0);
            chk($sformatf("reset frame_done%0d", i), fd[i], 0);
            chk($sformatf("reset overflow%0d", i), ov[i], 0);
            chk($sformatf("reset frame_count%0d", i), fc[i], 0);
        end
        #80 rst_n = 1'b1;
        cyc(2);

        // 4x2 RGB565 frame of 0xF800
        send_frame(1, 0, 0, 0, 2, 4, -1, 0, 0, 8'hF8, 8'h00);
        wait_empty(0, 1);
        chk("t1 frame_count", fc[0], 16'd1);
        chk("t1 last data", last_d[0], 16'hF800);
        chk("t1 last addr", last_a[0], 19'd7);
        chk("t1 frame_err", last_e[0], 1'b0);

        // gray mode: Y=0x80, chroma byte ignored
        send_frame(1, 0, 1, 0, 2, 4, -1, 0, 0, 8'h80, 8'h3C);
        wait_empty(0, 1);
        chk("t2 gray data", last_d[0], 16'h8410);
        chk("t2 frame_count", fc[0], 16'd2);

        // 2x decimation on an 8x4 frame
        send_frame(0, 1, 0, 0, 4, 8, -1, 0, 1, 8'h00, 8'h00);
        wait_empty(1, 1);
        chk("t3 kept pixels", 64'(npop[1]), 8);
        chk("t3 last addr", last_a[1], 19'd7);
        chk("t3 frame_err", last_e[1], 1'b0);
        chk("t3 frame_count", fc[1], 16'd1);

        // consumer stalled: 12 pixels into an 8-entry FIFO
        send_frame(1, 0, 0, 1, 3, 4, -1, 0, 1, 8'h00, 8'h00);
        wait_empty(0, 0);
        chk("t4 overflow", ov[0], 1'b1);
        chk("t4 pix_valid held", pv[0], 1'b1);
        chk("t4 head addr", pa[0], 19'd0);
        chk("t4 frame_err", last_e[0], 1'b1);
        ready = 1'b1;
        wait_empty(0, 1);
        chk("t4 last drained addr", last_a[0], 19'd7);
        chk("t4 frame_count", fc[0], 16'd3);

        // second line one pixel short with a dangling odd byte
        send_frame(1, 0, 0, 0, 2, 4, 1, 1, 1, 8'h00, 8'h00);
        wait_empty(0, 1);
        chk("t5 frame_err", last_e[0], 1'b1);
        chk("t5 last addr", last_a[0], 19'd6);
        chk("t5 overflow cleared", ov[0], 1'b0);
        chk("t5 frame_count", fc[0], 16'd4);

        // capture not armed: frame ignored
        send_frame(0, 0, 0, 0, 2, 4, -1, 0, 1, 8'h00, 8'h00);
        cyc(4);
        chk("t6 frame_count0 unchanged", fc[0], 16'd4);
        chk("t6 frame_count1 unchanged", fc[1], 16'd1);
        chk("t6 no pix_valid0", pv[0], 1'b0);
        chk("t6 no pix_valid1", pv[1], 1'b0);

        // reset in the middle of a line
        en[0] = 1'b1;
        vsync = 1'b0;
        cyc(2);
        href = 1'b1;
        put(8'h12);
        rst_n = 1'b0;
        #1;
        chk("t6 rst pix_valid", pv[0], 1'b0);
        chk("t6 rst pix_data", pd[0], 16'h0);
        chk("t6 rst pix_addr", pa[0], 19'h0);
        chk("t6 rst frame_done", fd[0], 1'b0);
        chk("t6 rst frame_err", fe[0], 1'b0);
        chk("t6 rst overflow", ov[0], 1'b0);
        chk("t6 rst frame_count", fc[0], 16'h0);
        #9;
        href = 1'b0; vsync = 1'b1; en[0] = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cnt_exp[0] = 0; cnt_exp[1] = 0;
        cyc(2);

        // engine recovers with a clean frame after reset
        send_frame(1, 0, 0, 0, 2, 4, -1, 0, 0, 8'hF8, 8'h00);
        wait_empty(0, 1);
        chk("t7 frame_count after reset", fc[0], 16'd1);
        chk("t7 last addr", last_a[0], 19'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
